// File: rtl/pinf_line_reverse.sv
`default_nettype none
// ============================================================================
// Module      : pinf_line_reverse
// Description : Ping-pong line buffer on the 32-bit pixel path. Each line
//               is captured into one bank and replayed one line later with
//               the word order reversed (last word first).
//               Optional build macro PINF_HALF_SWAP_EN also swaps the two
//               16-bit halves of every word (full 16bpp horizontal mirror).
// Revision    : 1.0 - initial release
// ============================================================================
module pinf_line_reverse #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fs,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_fs,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ls,
    output logic              o_le,
    output logic              o_ovf,
    output logic              o_ovr
);

    localparam int ADDR_W = $clog2(MAX_WORDS);

    localparam logic [ADDR_W:0]   c_max_words = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } rd_state_t;

    rd_state_t r_state;
    rd_state_t w_state_nxt;

    logic              r_wbank;
    logic              r_rbank;
    logic              r_rsel;
    logic              r_prev_valid;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] w_raddr_nxt;
    logic [ADDR_W-1:0] w_waddr;

    logic              r_valid;
    logic              r_ls;
    logic              r_le;
    logic              r_fs;
    logic              r_ovf;
    logic              r_ovr;

    logic              w_rd_busy;
    logic              w_line_end;
    logic              w_handover;
    logic              w_wr_full;
    logic              w_we;
    logic              w_ren;
    logic              w_first;
    logic              w_last;

    logic [DATA_W-1:0] w_bank_rd [2];
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_odata;

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    assign w_rd_busy  = (r_state != S_IDLE);
    assign w_line_end = !i_fs && !i_valid && r_prev_valid;
    assign w_handover = w_line_end && !w_rd_busy;
    assign w_wr_full  = (r_wcnt == c_max_words);
    // A frame start restarts the line, so its word always lands at address 0.
    assign w_we       = i_valid && (i_fs || !w_wr_full);
    assign w_waddr    = i_fs ? '0 : r_wcnt[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbank      <= 1'b0;
            r_wcnt       <= '0;
            r_prev_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_prev_valid <= i_valid;
            if (i_fs) begin
                r_wcnt <= i_valid ? c_cnt_one : '0;
            end else if (i_valid) begin
                if (!w_wr_full) begin
                    r_wcnt <= r_wcnt + c_cnt_one;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_line_end) begin
                r_wcnt <= '0;
                if (w_rd_busy) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_wbank <= ~r_wbank;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rbank <= 1'b0;
            r_raddr <= '0;
            r_rsel  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_raddr <= w_raddr_nxt;
            if (w_handover) begin
                r_rbank <= r_wbank;
            end
            if (w_ren) begin
                r_rsel <= r_rbank;
            end
        end
    end

    // The lower ADDR_W bits of a full count are zero, so subtracting one in
    // ADDR_W-bit arithmetic still gives MAX_WORDS-1 for a saturated line.
    always_comb begin
        w_state_nxt = r_state;
        w_raddr_nxt = r_raddr;
        w_ren       = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_handover) begin
                    w_state_nxt = S_LOAD;
                    w_raddr_nxt = r_wcnt[ADDR_W-1:0] - c_addr_one;
                end
            end
            S_LOAD, S_RUN: begin
                w_ren   = 1'b1;
                w_first = (r_state == S_LOAD);
                w_last  = (r_raddr == '0);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_raddr_nxt = r_raddr - c_addr_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_fs) begin
            w_state_nxt = S_IDLE;
            w_ren       = 1'b0;
            w_first     = 1'b0;
            w_last      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Line banks: single write port, registered read port
    // ------------------------------------------------------------------
    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic [DATA_W-1:0] r_mem [MAX_WORDS];
            logic [DATA_W-1:0] r_rd;

            always_ff @(posedge clk) begin
                if (w_we && (r_wbank == 1'(b))) begin
                    r_mem[w_waddr] <= i_data;
                end
                if (w_ren && (r_rbank == 1'(b))) begin
                    r_rd <= r_mem[r_raddr];
                end
            end

            assign w_bank_rd[b] = r_rd;
        end
    endgenerate

    assign w_rdata = w_bank_rd[r_rsel];

`ifdef PINF_HALF_SWAP_EN
    assign w_odata = {w_rdata[DATA_W/2-1:0], w_rdata[DATA_W-1:DATA_W/2]};
`else
    assign w_odata = w_rdata;
`endif

    // ------------------------------------------------------------------
    // Output control, aligned with the one-cycle bank read latency
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ls    <= 1'b0;
            r_le    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_valid <= w_ren;
            r_ls    <= w_first;
            r_le    <= w_last;
            r_fs    <= i_fs;
        end
    end

    assign o_fs    = r_fs;
    assign o_valid = r_valid;
    assign o_data  = r_valid ? w_odata : '0;
    assign o_ls    = r_ls;
    assign o_le    = r_le;
    assign o_ovf   = r_ovf;
    assign o_ovr   = r_ovr;

endmodule
`default_nettype wire

// File: doc/pinf_line_reverse.md
Name: pinf_line_reverse

Overview:
- Line-reversing stage on the 32-bit pixel-interface (pinf) path between the MIPI RX pixel output and the MIPI TX pixel input.
- Captures each incoming line of pixel words into a ping-pong pair of line banks.
- Replays the captured line one line later in reverse word order (last word first) while the next line is being captured.

Parameters:
- DATA_W, 32, pixel word width.
- MAX_WORDS, 1024, maximum words per line per bank.
- ADDR_W, $clog2(MAX_WORDS), bank address width (derived, not overridden).

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_fs  input  1  frame-start pulse, one cycle.
- i_valid  input  1  word valid; a contiguous high run is one line.
- i_data  input  DATA_W  pixel word.
- o_fs  output  1  frame-start pulse.
- o_valid  output  1  output word valid.
- o_data  output  DATA_W  reversed pixel word.
- o_ls  output  1  line-start pulse, coincident with the first o_valid word of a line.
- o_le  output  1  line-end pulse, coincident with the last o_valid word of a line.
- o_ovf  output  1  sticky: a line exceeded MAX_WORDS.
- o_ovr  output  1  sticky: a line completed while the previous readout was still busy.

Behaviour:
- Reset: all outputs 0; write bank = 0; write count = 0; reader IDLE.
- Banks: two DATA_W x MAX_WORDS RAMs; synchronous read, 1-cycle latency.
- Writer: each i_valid=1 cycle stores i_data at wbank[wcnt] and increments wcnt.
  - Words beyond MAX_WORDS are dropped, wcnt saturates at MAX_WORDS, and o_ovf is set.
- Line end = first cycle t with i_valid=0 after at least one valid cycle.
  - If reader IDLE: latch len=wcnt, hand wbank to reader, toggle wbank, clear wcnt.
  - If reader BUSY: set o_ovr, discard the line (no bank swap), clear wcnt.
- Reader states:
  - IDLE -> LOAD on handover; raddr = len-1.
  - LOAD (cycle t+1): issue read; -> RUN.
  - RUN: decrement raddr each cycle.
  - o_valid high from t+2 for exactly len consecutive cycles, with data in order word[len-1] .. word[0].
  - o_ls on the first word, o_le on the last; o_ls and o_le are both high when len=1.
  - -> IDLE on the cycle after the last word.
- Back-to-back lines: the writer may fill the other bank during RUN. A gap of one invalid cycle between lines is legal.
- i_fs:
  - Aborts any LOAD/RUN: o_valid drops the next cycle and no o_le is emitted.
  - Clears wcnt and the pending line.
  - o_fs pulses at t_fs+1.
  - i_fs with i_valid in the same cycle: the abort wins, and that word becomes word 0 of the new line.
- o_ovf and o_ovr clear only on rst.
- Width rules: wcnt and len are ADDR_W+1 bits; raddr wraps never, because the read stops at 0.

Optional Feature:
- Macro PINF_HALF_SWAP_EN.
- When defined: o_data = {word[15:0], word[31:16]}, i.e. 16-bit pixel order is also reversed inside each word, giving a full horizontal mirror for 16bpp packing.
- When undefined: words are output unmodified.

Test Plan:
- Line of 4 words A0..A3 followed by idle -> o_valid for 4 cycles starting 2 cycles after the line end; data A3,A2,A1,A0; o_ls with A3, o_le with A0.
- Two 1920/2=960-word lines with a 1-cycle gap -> both lines reversed, no o_ovr, second readout starts 2 cycles after the second line end.
- 1030-word line with MAX_WORDS=1024 -> o_ovf=1; readout of 1024 words, word1023..word0.
- 2-word line arriving while an 8-word readout is still RUN -> o_ovr=1, the 2-word line is never output, the 8-word readout completes intact.
- i_fs asserted mid-readout, 3 words in -> o_valid low the next cycle, no o_le, o_fs pulse; the following line is reversed correctly.
- Line 0x11112222, 0x33334444 with PINF_HALF_SWAP_EN -> outputs 0x44443333, 0x22221111.
